// File: rtl/wishbone_ctrl_stream_if.sv
// Wishbone-style bus interfaces for the stream-to-bus controller.
//
//   iWishbone_Ctrl : controller -> peripheral request lines
//     stb  strobe, a bus cycle is in progress
//     we   1 = write, 0 = read
//     adr  8-bit address
//     dat  8-bit write data
//   iWishbone_Peri : peripheral -> controller response lines
//     dat  8-bit read data, valid with ack
//     ack  cycle completes on an edge where stb and ack are both high
//
// In both interfaces the "master" modport is the controller's view and the
// "slave" modport is the peripheral's view.

interface iWishbone_Ctrl;
    logic       stb;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;

    modport master (output stb, output we, output adr, output dat);
    modport slave  (input  stb, input  we, input  adr, input  dat);
endinterface

interface iWishbone_Peri;
    logic [7:0] dat;
    logic       ack;

    modport master (input  dat, input  ack);
    modport slave  (output dat, output ack);
endinterface

// File: rtl/wishbone_ctrl_stream.sv
// Byte-stream to Wishbone bridge. A host sends a small command frame over a
// valid/ready byte stream; the block runs one bus cycle and answers with a
// status byte (plus the read data byte for successful reads).
//
// Frame on rx:  header (bit7 = we, bits6:0 must be 0), address, [data if we]
// Reply on tx:  status (0x00 ok, 0xE1 bad header, 0xEE bus timeout),
//               then read data only for a read that completed with 0x00.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/valid/ready command byte stream in
//   tx_data/valid/ready response byte stream out
//   wbc_c               bus request (stb, we, adr, dat)
//   wbc_p               bus response (dat, ack)
//
// pTimeout: number of stb cycles allowed without ack (1..65535).

module wishbone_ctrl_stream #(
    parameter int unsigned pTimeout = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,

    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,

    iWishbone_Ctrl.master wbc_c,
    iWishbone_Peri.master wbc_p
);

    // Wide enough to hold pTimeout itself, so no value in range can wrap.
    localparam int unsigned CW = $clog2(pTimeout + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(pTimeout - 1);

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_HDR = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_STATUS,
        S_RDATA
    } state_t;

    state_t        state, state_n;

    logic          we_q;
    logic [7:0]    adr_q;
    logic [7:0]    dat_q;
    logic          stb_q;
    logic [CW-1:0] cnt;
    logic [7:0]    status;
    logic [7:0]    rdata;

    logic          rx_fire;
    logic          tx_fire;
    logic          hdr_bad;
    logic          bus_ack;
    logic          bus_tmo;

    // ------------------------------------------------------------------
    // Handshake and bus qualifiers
    // ------------------------------------------------------------------
    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    assign hdr_bad = |rx_data[6:0];

    // ack only counts while stb is up, so a late ack after a timeout (or
    // any stray ack while idle) never completes anything.
    assign bus_ack = stb_q & wbc_p.ack;
    // ack wins over timeout when both land on the last allowed cycle.
    assign bus_tmo = stb_q & ~wbc_p.ack & (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_n;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        unique case (state)
            S_HDR: begin
                if (rx_fire) state_n = hdr_bad ? S_STATUS : S_ADDR;
            end
            S_ADDR: begin
                if (rx_fire) state_n = we_q ? S_DATA : S_BUS;
            end
            S_DATA: begin
                if (rx_fire) state_n = S_BUS;
            end
            S_BUS: begin
                if (bus_ack || bus_tmo) state_n = S_STATUS;
            end
            S_STATUS: begin
                // Read data follows only a read that finished cleanly.
                if (tx_fire) state_n = (!we_q && status == ST_OK) ? S_RDATA : S_HDR;
            end
            S_RDATA: begin
                if (tx_fire) state_n = S_HDR;
            end
            default: state_n = S_HDR;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame fields, bus strobe, timeout counter, response bytes
    // ------------------------------------------------------------------
    // stb is registered and set on the edge that accepts the last frame
    // byte, so it is high exactly while the FSM sits in BUS and the bus
    // fields cannot move underneath it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            adr_q  <= 8'h00;
            dat_q  <= 8'h00;
            stb_q  <= 1'b0;
            cnt    <= '0;
            status <= 8'h00;
            rdata  <= 8'h00;
        end else begin
            unique case (state)
                S_HDR: begin
                    if (rx_fire) begin
                        if (hdr_bad) status <= ST_BAD_HDR;
                        else         we_q   <= rx_data[7];
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        adr_q <= rx_data;
                        if (!we_q) begin
                            stb_q <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        dat_q <= rx_data;
                        stb_q <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        stb_q  <= 1'b0;
                        status <= ST_OK;
                        if (!we_q) rdata <= wbc_p.dat;
                    end else if (bus_tmo) begin
                        stb_q  <= 1'b0;
                        status <= ST_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs: decoded from state so reset clears them at once and
    // rx_ready / tx_valid can never overlap.
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state)
            S_HDR, S_ADDR, S_DATA: rx_ready = 1'b1;
            S_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status;
            end
            S_RDATA: begin
                tx_valid = 1'b1;
                tx_data  = rdata;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign wbc_c.stb = stb_q;
    assign wbc_c.we  = we_q;
    assign wbc_c.adr = adr_q;
    assign wbc_c.dat = dat_q;

endmodule

// File: tb/tb_wishbone_ctrl_stream.sv
// Self-checking bench for wishbone_ctrl_stream (pTimeout = 4).
// A directed table of frames, hand-written reset / late-ack sequences and a
// randomized batch checked against a frame-level reference model.

module tb_wishbone_ctrl_stream;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    iWishbone_Ctrl wbc_c_if ();
    iWishbone_Peri wbc_p_if ();

    wishbone_ctrl_stream #(.pTimeout(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wbc_c    (wbc_c_if),
        .wbc_p    (wbc_p_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Peripheral + host-side monitor, all at negedge (away from clk rise).
    // Only this block writes the signals/counters below it.
    // ------------------------------------------------------------------
    int         ack_delay = 1000;   // stb cycle index at which to ack
    logic [7:0] pdat      = 8'h00;
    logic       force_ack = 1'b0;   // ack driven whenever stb is low
    int         stall_req = 0;
    int         frame_id  = 0;

    int         stb_idx = 0, stb_cycles = 0;
    int         stall_left = 0, stall_frame = -1;
    logic       cap_we;
    logic [7:0] cap_adr, cap_dat, last_tx;
    logic       stalled = 1'b0;
    int         stab_bad = 0, excl_bad = 0, bp_bad = 0;
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (rx_ready && tx_valid) excl_bad++;

        if (wbc_c_if.stb) begin
            if (stb_idx == 0) begin
                cap_we  = wbc_c_if.we;
                cap_adr = wbc_c_if.adr;
                cap_dat = wbc_c_if.dat;
            end else if (wbc_c_if.we != cap_we || wbc_c_if.adr != cap_adr ||
                         wbc_c_if.dat != cap_dat) begin
                stab_bad++;
            end
            wbc_p_if.ack = (stb_idx == ack_delay);
            wbc_p_if.dat = (stb_idx == ack_delay) ? pdat : 8'h00;
            stb_idx++;
            stb_cycles++;
        end else begin
            stb_idx      = 0;
            wbc_p_if.ack = force_ack;
            wbc_p_if.dat = 8'hFF;
        end

        if (tx_valid) begin
            if (stall_frame != frame_id) begin
                stall_frame = frame_id;
                stall_left  = stall_req;
            end
            if (stalled && tx_data != last_tx) bp_bad++;
            if (stall_left > 0) begin
                if (rx_ready) bp_bad++;
                stalled  = 1'b1;
                last_tx  = tx_data;
                stall_left--;
                tx_ready = 1'b0;
            end else begin
                stalled  = 1'b0;
                tx_ready = 1'b1;
                tx_q.push_back(tx_data);
            end
        end else begin
            stalled  = 1'b0;
            tx_ready = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Host rx driver
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        rx_valid = 1'b0;
        chk("rx byte accepted", int'(ok), 1);
    endtask

    // ------------------------------------------------------------------
    // One frame: drive, wait (bounded) for reply, compare
    // ------------------------------------------------------------------
    task automatic run_frame(input string tag, input logic [7:0] hdr, adr, dat,
                             input int ad, input logic [7:0] pd, input int stall,
                             input int exp_n, input logic [7:0] e0, e1,
                             input int exp_stb);
        int q0, s0, n;
        bit done;
        ack_delay = ad;
        pdat      = pd;
        stall_req = stall;
        frame_id++;
        q0 = tx_q.size();
        s0 = stb_cycles;

        send_byte(hdr);
        if (hdr[6:0] == 7'd0) begin
            send_byte(adr);
            if (hdr[7]) send_byte(dat);
        end

        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk); #1;
            if (tx_q.size() - q0 >= exp_n && rx_ready && !tx_valid) done = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;

        chk({tag, " reply complete"}, int'(done), 1);
        n = tx_q.size() - q0;
        chk({tag, " tx count"}, n, exp_n);
        if (n > 0 && exp_n > 0) chk({tag, " tx byte0"}, tx_q[q0], e0);
        if (n > 1 && exp_n > 1) chk({tag, " tx byte1"}, tx_q[q0+1], e1);
        chk({tag, " stb cycles"}, stb_cycles - s0, exp_stb);
        if (exp_stb > 0) begin
            chk({tag, " bus we"},  cap_we,  hdr[7]);
            chk({tag, " bus adr"}, cap_adr, adr);
            if (hdr[7]) chk({tag, " bus dat"}, cap_dat, dat);
        end
    endtask

    // Frame-level reference model: what the host should see for a frame.
    task automatic model(input logic [7:0] hdr, input int ad, input logic [7:0] pd,
                         output int n, output logic [7:0] e0, e1, output int stb);
        e1 = 8'h00;
        if (hdr[6:0] != 7'd0) begin
            n = 1; e0 = 8'hE1; stb = 0;
        end else if (ad >= T) begin
            n = 1; e0 = 8'hEE; stb = T;
        end else begin
            stb = ad + 1;
            e0  = 8'h00;
            if (hdr[7]) n = 1;
            else begin n = 2; e1 = pd; end
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] hdr, adr, dat;
        int         ad;
        logic [7:0] pd;
        int         stall;
        int         n;
        logic [7:0] e0, e1;
        int         stb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int         q0, n, stb, ad, st, kind;
        logic [7:0] hdr, adr, dat, pd, e0, e1;
        bit         seen;

        tbl[0] = '{"write",       8'h80, 8'h12, 8'h5A, 2,    8'h00, 0, 1, 8'h00, 8'h00, 3};
        tbl[1] = '{"read",        8'h00, 8'h34, 8'h00, 0,    8'hC3, 0, 2, 8'h00, 8'hC3, 1};
        tbl[2] = '{"timeout",     8'h00, 8'h56, 8'h00, 1000, 8'h11, 0, 1, 8'hEE, 8'h00, 4};
        tbl[3] = '{"bad_hdr",     8'h81, 8'h00, 8'h00, 0,    8'h00, 0, 1, 8'hE1, 8'h00, 0};
        tbl[4] = '{"backpress",   8'h00, 8'h34, 8'h00, 1,    8'hC3, 5, 2, 8'h00, 8'hC3, 2};
        tbl[5] = '{"ack_last",    8'h80, 8'hA5, 8'h3C, 3,    8'h00, 0, 1, 8'h00, 8'h00, 4};
        tbl[6] = '{"ack_late",    8'h80, 8'h5A, 8'hC3, 4,    8'h00, 0, 1, 8'hEE, 8'h00, 4};
        tbl[7] = '{"bad_hdr_7f",  8'h7F, 8'h00, 8'h00, 0,    8'h00, 0, 1, 8'hE1, 8'h00, 0};

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // Reset state
        #13;
        chk("reset rx_ready", rx_ready, 1);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data",  tx_data, 8'h00);
        chk("reset stb",      wbc_c_if.stb, 0);
        chk("reset we",       wbc_c_if.we, 0);
        chk("reset adr",      wbc_c_if.adr, 8'h00);
        chk("reset dat",      wbc_c_if.dat, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].name, tbl[i].hdr, tbl[i].adr, tbl[i].dat, tbl[i].ad,
                      tbl[i].pd, tbl[i].stall, tbl[i].n, tbl[i].e0, tbl[i].e1, tbl[i].stb);

        // Ack held high around a timed-out read: only the stb-low cycles see it,
        // so it must change nothing.
        force_ack = 1'b1;
        run_frame("late_ack", 8'h00, 8'h77, 8'h00, 1000, 8'hAA, 6, 1, 8'hEE, 8'h00, 4);
        force_ack = 1'b0;

        // Reset in the middle of a bus cycle
        ack_delay = 1000;
        stall_req = 0;
        frame_id++;
        q0 = tx_q.size();
        send_byte(8'h80);
        send_byte(8'h22);
        send_byte(8'h99);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = wbc_c_if.stb;
        end
        chk("mid-bus stb seen", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid-bus rst stb drop", wbc_c_if.stb, 0);
        chk("mid-bus rst rx_ready", rx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("post-rst rx_ready", rx_ready, 1);
        chk("post-rst tx_valid", tx_valid, 0);
        chk("post-rst no reply", tx_q.size() - q0, 0);

        // Randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 4);
            ad   = $urandom_range(0, 6);
            st   = $urandom_range(0, 3);
            pd   = 8'($urandom);
            adr  = 8'($urandom);
            dat  = 8'($urandom);
            if (kind == 0) hdr = {1'($urandom), 7'($urandom_range(1, 127))};
            else           hdr = kind[0] ? 8'h80 : 8'h00;
            model(hdr, ad, pd, n, e0, e1, stb);
            run_frame("random", hdr, adr, dat, ad, pd, st, n, e0, e1, stb);
        end

        chk("rx_ready/tx_valid exclusive", excl_bad, 0);
        chk("bus fields stable under stb", stab_bad, 0);
        chk("tx stable under backpressure", bp_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
